osd_text_writer: RTL and testbench
==================================

// Module: osd_text_writer
// PURPOSE
// - Write-side companion of the OSD overlay. Consumes a byte stream of
//   characters/control codes (valid/ready) and writes the OSD character RAM
//   (port A).
// - Maintains a text cursor and supports clear-screen and cursor positioning.
// - Drives osd_active with a retriggerable display timeout.
// - Sits between the debug/status source (CPU bridge or core FSM) and the
//   dual-port char RAM whose port B the overlay reads.
// PARAMETERS
// - SCREEN_COLS     48          text columns; must be <= 64
// - SCREEN_ROWS     32          text rows; must be <= 32
// - CLEAR_CHAR      8'h20       code written to every cell by clear-screen
// - TIMEOUT_CYCLES  96_000_000  osd_active hold time in clk cycles (3 s at 32 MHz)
// - TMR_W           27          timeout counter width; 2**TMR_W > TIMEOUT_CYCLES
// PORTS
// - clk         in   1   master clock (32 MHz)
// - reset_n     in   1   asynchronous active-low reset
// - cmd_valid   in   1   cmd_data valid
// - cmd_ready   out  1   block accepts cmd_data this cycle
// - cmd_data    in   8   character or control code
// - ram_addr_a  out  11  char RAM address {row[4:0], col[5:0]}; same map as port B
// - ram_data_a  out  8   char RAM write data
// - ram_we_a    out  1   char RAM write enable, one-cycle pulse per write
// - osd_active  out  1   high while timeout counter is non-zero
// - busy        out  1   high while a clear-screen sweep runs
// BEHAVIOUR
// - Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
// - Reset state: all outputs 0. FSM in IDLE. Cursor (row,col) = (0,0). Timer = 0.
//   - cmd_ready comes from a flag that resets to 0 and sets to 1 one cycle
//     after reset_n deasserts.
// - Handshake: a byte is accepted on a rising edge with cmd_valid & cmd_ready.
//   cmd_ready = flag & (state in IDLE/ARG_ROW/ARG_COL).
// - Byte decode in IDLE:
//   - 8'h0C CLR: go to CLEAR.
//   - 8'h0A LF: col=0; row=row+1, wrapping SCREEN_ROWS-1 -> 0.
//   - 8'h0D CR: col=0.
//   - 8'h1B ESC: go to ARG_ROW.
//   - Any other value: write it at the cursor, then advance the cursor.
//     col=col+1. At col==SCREEN_COLS-1: col=0 and row advances as for LF.
// - ARG_ROW: the next accepted byte sets row = min(byte, SCREEN_ROWS-1). Go to ARG_COL.
// - ARG_COL: the next accepted byte sets col = min(byte, SCREEN_COLS-1). Go to IDLE.
//   No RAM write in either state.
// - Write timing: all RAM outputs are registered. A character accepted at edge N
//   gives ram_we_a=1 with addr/data during cycle N+1. Back-to-back accepts give
//   back-to-back writes.
// - CLEAR:
//   - One write per cycle of CLEAR_CHAR, row-major (0,0) .. (ROWS-1, COLS-1).
//   - Columns >= SCREEN_COLS are never addressed.
//   - busy=1 and cmd_ready=0 for the whole sweep.
//   - On the last write, cursor=(0,0) and state returns to IDLE.
//     cmd_ready is high on the cycle after the last ram_we_a.
// - Timeout: every accepted byte, including LF/CR/ESC and arguments, reloads the
//   counter to TIMEOUT_CYCLES. Otherwise it decrements when non-zero.
//   osd_active = (counter != 0), registered.
// - Overflow: a bad argument is clamped; a cursor past the last cell wraps to (0,0).
//   There is no scrolling.
// - Reset mid-operation: an assertion mid-CLEAR or mid-ESC sequence aborts it
//   immediately. ram_we_a drops asynchronously. RAM contents already written remain.
// - cmd_valid low between an ESC and its arguments is legal. The FSM waits indefinitely.
// STRUCTURE
// - osd_pkg holds:
//   - state enum typedef {IDLE, ARG_ROW, ARG_COL, CLEAR}
//   - code constants OSD_CLR/OSD_LF/OSD_CR/OSD_ESC
//   - default SCREEN_COLS/ROWS and CLEAR_CHAR
//   - function osd_addr(row,col) -> 11-bit {row[4:0], col[5:0]}, shared with the overlay
// - One sub-module, osd_timeout_timer: reload / decrement / active flag.
// - Cursor logic and FSM stay inline.
// TESTING
// - T1 reset, then 'A' (8'h41): one ram_we_a, addr 11'h000, data 8'h41, one
//   cycle after accept; osd_active=1; cursor=(0,1).
// - T2 49x 'B' from (0,0): 48th write at 11'h02F, 49th at 11'h040.
//   Never any col >= 48.
// - T3 ESC,31,47,'Z',LF,'Q': 'Z' written at 11'h7EF; 'Q' at 11'h040 (wrap then LF).
//   ESC,40,70,'X': 'X' at 11'h7EF (clamped).
// - T4 8'h0C: exactly 1536 consecutive writes of 8'h20 covering all 32x48 cells.
//   Monitor: cmd_ready=0 and busy=1 throughout; next 'A' lands at 11'h000.
// - T5 TIMEOUT_CYCLES=100: single byte gives osd_active high for 100 cycles, then low.
//   A second byte at cycle 50 extends it to cycle 150.
// - T6 reset_n low after the 500th clear write: ram_we_a=0 immediately.
//   After release, cmd_ready rises one cycle later and 'C' writes 11'h000.

Source files
------------

// File: rtl/osd_pkg.sv
// osd_pkg: shared types, control codes and address map for the OSD writer and overlay
package osd_pkg;
  typedef enum logic [1:0] {IDLE, ARG_ROW, ARG_COL, CLEAR} osd_state_t;
  localparam logic [7:0] OSD_CLR = 8'h0C;
  localparam logic [7:0] OSD_LF = 8'h0A;
  localparam logic [7:0] OSD_CR = 8'h0D;
  localparam logic [7:0] OSD_ESC = 8'h1B;
  localparam int OSD_COLS = 48;
  localparam int OSD_ROWS = 32;
  localparam logic [7:0] OSD_CLEAR_CHAR = 8'h20;
  function automatic logic [10:0] osd_addr(input logic [4:0] row, input logic [5:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/osd_timeout_timer.sv
// osd_timeout_timer: retriggerable hold counter; active while the count is non-zero
module osd_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 96_000_000,
  parameter int TMR_W = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  output logic active
);
  logic [TMR_W-1:0] cnt, cnt_nxt;
  always_comb cnt_nxt = reload ? TMR_W'(TIMEOUT_CYCLES) : (cnt != '0 ? cnt - 1'b1 : cnt);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      active <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      active <= cnt_nxt != '0;
    end
endmodule

// File: rtl/osd_text_writer.sv
// osd_text_writer: turns a char/control byte stream into OSD char RAM writes with cursor, clear and timeout
module osd_text_writer
  import osd_pkg::*;
#(
  parameter int SCREEN_COLS = OSD_COLS,
  parameter int SCREEN_ROWS = OSD_ROWS,
  parameter logic [7:0] CLEAR_CHAR = OSD_CLEAR_CHAR,
  parameter int TIMEOUT_CYCLES = 96_000_000,
  parameter int TMR_W = 27
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  output logic [10:0] ram_addr_a,
  output logic [7:0]  ram_data_a,
  output logic        ram_we_a,
  output logic        osd_active,
  output logic        busy
);
  localparam logic [4:0] LAST_ROW = 5'(SCREEN_ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(SCREEN_COLS - 1);
  localparam logic [7:0] MAX_ROW8 = 8'(SCREEN_ROWS - 1);
  localparam logic [7:0] MAX_COL8 = 8'(SCREEN_COLS - 1);
  osd_state_t state;
  logic rdy_flag, acc;
  logic [4:0] row, row_inc, row_nx;
  logic [5:0] col, col_nx;
  assign cmd_ready = rdy_flag & (state != CLEAR);
  assign busy = state == CLEAR;
  assign acc = cmd_valid & cmd_ready;
  assign row_inc = row == LAST_ROW ? 5'd0 : row + 5'd1;
  assign col_nx = col == LAST_COL ? 6'd0 : col + 6'd1;
  assign row_nx = col == LAST_COL ? row_inc : row;
  // During CLEAR the cursor doubles as the sweep position of the write currently on the port
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rdy_flag <= 1'b0;
      row <= '0;
      col <= '0;
      ram_we_a <= 1'b0;
      ram_addr_a <= '0;
      ram_data_a <= '0;
    end else begin
      rdy_flag <= 1'b1;
      ram_we_a <= 1'b0;
      if (state == CLEAR) begin
        if (row == LAST_ROW && col == LAST_COL) begin
          state <= IDLE;
          row <= '0;
          col <= '0;
        end else begin
          row <= row_nx;
          col <= col_nx;
          ram_we_a <= 1'b1;
          ram_addr_a <= osd_addr(row_nx, col_nx);
          ram_data_a <= CLEAR_CHAR;
        end
      end else if (acc) begin
        case (state)
          IDLE:
            if (cmd_data == OSD_CLR) begin
              state <= CLEAR;
              row <= '0;
              col <= '0;
              ram_we_a <= 1'b1;
              ram_addr_a <= '0;
              ram_data_a <= CLEAR_CHAR;
            end else if (cmd_data == OSD_LF) begin
              col <= '0;
              row <= row_inc;
            end else if (cmd_data == OSD_CR) begin
              col <= '0;
            end else if (cmd_data == OSD_ESC) begin
              state <= ARG_ROW;
            end else begin
              ram_we_a <= 1'b1;
              ram_addr_a <= osd_addr(row, col);
              ram_data_a <= cmd_data;
              row <= row_nx;
              col <= col_nx;
            end
          ARG_ROW: begin
            row <= cmd_data > MAX_ROW8 ? LAST_ROW : cmd_data[4:0];
            state <= ARG_COL;
          end
          ARG_COL: begin
            col <= cmd_data > MAX_COL8 ? LAST_COL : cmd_data[5:0];
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  osd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMR_W(TMR_W)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .reload(acc),
    .active(osd_active)
  );
endmodule

// File: tb/tb_osd_text_writer.sv
// tb_osd_text_writer: directed + random byte stream checked against a cursor/screen reference model
module tb_osd_text_writer;
  logic clk = 0, reset_n = 0, cmd_valid = 0;
  logic [7:0] cmd_data = 0;
  logic cmd_ready, ram_we_a, osd_active, busy;
  logic [10:0] ram_addr_a;
  logic [7:0] ram_data_a;
  int vectors = 0, miscompares = 0;
  int mrow = 0, mcol = 0, mst = 0;
  always #5 clk = ~clk;
  osd_text_writer #(.TIMEOUT_CYCLES(100), .TMR_W(27)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
    .ram_we_a(ram_we_a), .osd_active(osd_active), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // screen model: mst 0 = text, 1 = awaiting row argument, 2 = awaiting column argument
  function automatic bit model(input logic [7:0] b, output logic [10:0] a);
    a = '0;
    if (mst == 1) begin
      mrow = b > 31 ? 31 : int'(b);
      mst = 2;
      return 0;
    end
    if (mst == 2) begin
      mcol = b > 47 ? 47 : int'(b);
      mst = 0;
      return 0;
    end
    if (b == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % 32;
      return 0;
    end
    if (b == 8'h0D) begin
      mcol = 0;
      return 0;
    end
    if (b == 8'h1B) begin
      mst = 1;
      return 0;
    end
    a = 11'(mrow * 64 + mcol);
    mcol++;
    if (mcol == 48) begin
      mcol = 0;
      mrow = (mrow + 1) % 32;
    end
    return 1;
  endfunction
  task automatic accept(input logic [7:0] b);
    int w = 0;
    cmd_data = b;
    cmd_valid = 1;
    while (!cmd_ready && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask
  task automatic send(input logic [7:0] b);
    logic [10:0] a;
    bit w;
    accept(b);
    w = model(b, a);
    @(negedge clk);
    check("we", ram_we_a, w);
    if (w) begin
      check("addr", ram_addr_a, a);
      check("data", ram_data_a, b);
    end
  endtask
  task automatic do_clear(input int abort_at);
    accept(8'h0C);
    for (int k = 0; k < 1536; k++) begin
      @(negedge clk);
      check("clr_we", ram_we_a, 1);
      check("clr_addr", ram_addr_a, (k / 48) * 64 + k % 48);
      check("clr_data", ram_data_a, 8'h20);
      check("clr_busy", busy, 1);
      check("clr_ready", cmd_ready, 0);
      if (k + 1 == abort_at) begin
        reset_n = 0;
        #1 check("abort_we", ram_we_a, 0);
        mrow = 0;
        mcol = 0;
        mst = 0;
        return;
      end
    end
    @(negedge clk);
    check("clr_end_we", ram_we_a, 0);
    check("clr_end_busy", busy, 0);
    check("clr_end_ready", cmd_ready, 1);
    mrow = 0;
    mcol = 0;
    mst = 0;
  endtask
  initial begin
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("rst_we", ram_we_a, 0);
    check("rst_addr", ram_addr_a, 0);
    check("rst_data", ram_data_a, 0);
    check("rst_active", osd_active, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    reset_n = 1;
    #1 check("ready_at_release", cmd_ready, 0);
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);
    send(8'h41);
    check("t1_active", osd_active, 1);
    send(8'h1B); send(8'h00); send(8'h00);
    for (int i = 0; i < 49; i++) send(8'h42);
    send(8'h1B); send(8'd31); send(8'd47); send(8'h5A); send(8'h0A); send(8'h51);
    send(8'h1B); send(8'd40); send(8'd70); send(8'h58);
    do_clear(0);
    send(8'h41);
    repeat (120) @(negedge clk);
    check("t5_idle", osd_active, 0);
    accept(8'h0D);
    mcol = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      check("t5_single", osd_active, k < 100);
    end
    accept(8'h0D);
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (k == 49) begin
        check("t5_ready", cmd_ready, 1);
        cmd_data = 8'h0D;
        cmd_valid = 1;
      end
      if (k == 50) cmd_valid = 0;
      check("t5_extend", osd_active, k < 150);
    end
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: send(8'h0A);
        1: send(8'h0D);
        2: begin
          send(8'h1B);
          send(8'($urandom_range(0, 255)));
          if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
          send(8'($urandom_range(0, 255)));
        end
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0A || b == 8'h0D || b == 8'h1B || b == 8'h0C) b = 8'h78;
          send(b);
        end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check("gap_we", ram_we_a, 0);
      end
    end
    do_clear(500);
    repeat (2) @(negedge clk);
    check("t6_rst_ready", cmd_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_we", ram_we_a, 0);
    reset_n = 1;
    #1 check("t6_ready_release", cmd_ready, 0);
    @(negedge clk);
    check("t6_ready_after", cmd_ready, 1);
    send(8'h43);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
